prog_func_lut: RTL

Programmable N-input single-output boolean function unit. It is the parametrised successor to our fixed decoder-plus-mux function blocks. The truth table is not hard-wired. It is loaded at run time as a 2^N_IN-bit table over a valid/ready config stream into a shadow buffer, then committed atomically to an active table. Evaluation is a registered mux-tree lookup that keeps running during a reload, so function logic can be swapped without a stall.

---
 rtl/prog_func_lut.sv | 112 +++++++++++
 1 files changed

// File: rtl/prog_func_lut.sv
// prog_func_lut: programmable N_IN-input, single-output boolean function unit.
//
// The truth table (TBL = 2^N_IN bits) is streamed in over a valid/ready
// config port. Beats land in a shadow buffer. The whole table is then
// committed to the active table on the edge that accepts the last beat.
// Evaluation is a registered lookup into the active table with latency 1.
// It keeps running while a new table is being loaded.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   cfg_start   pulse: begin a new table load, discarding any partial shadow
//   cfg_valid   config beat valid
//   cfg_ready   config beat can be accepted (high only while loading)
//   cfg_data    table beat, LSB-first; beat 0 = table bits [LOAD_W-1:0]
//   tbl_loaded  an active table has been committed since reset
//   tbl_gen     commit counter, wraps 15 -> 0
//   in_valid    evaluate request
//   in_data     function input vector (index into the table)
//   out_valid   result valid
//   out_r       function result
//   out_err     result produced with no table loaded
module prog_func_lut #(
    parameter int N_IN   = 5,
    parameter int LOAD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [LOAD_W-1:0] cfg_data,
    output logic              tbl_loaded,
    output logic [3:0]        tbl_gen,
    input  logic              in_valid,
    input  logic [N_IN-1:0]   in_data,
    output logic              out_valid,
    output logic              out_r,
    output logic              out_err
);

    localparam int TBL   = 1 << N_IN;
    localparam int BEATS = TBL / LOAD_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_ARMED = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] beat_cnt;
    logic [TBL-1:0]   shadow;
    logic [TBL-1:0]   active;
    logic [TBL-1:0]   shadow_merged;
    logic             beat_acc;
    logic             last_beat;

    // cfg_start takes priority over a beat offered in the same cycle.
    // The merged view lets the final beat go straight into the active
    // table on the commit edge, without waiting a cycle for the shadow.
    always_comb begin
        beat_acc      = (state == ST_LOAD) && cfg_ready && cfg_valid && !cfg_start;
        last_beat     = (beat_cnt == CNT_W'(BEATS - 1));
        shadow_merged = shadow;
        shadow_merged[int'(beat_cnt) * LOAD_W +: LOAD_W] = cfg_data;
    end

    // Config path: load sequencing, shadow capture and atomic commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            cfg_ready  <= 1'b0;
            beat_cnt   <= '0;
            shadow     <= '0;
            active     <= '0;
            tbl_loaded <= 1'b0;
            tbl_gen    <= '0;
        end else if (cfg_start) begin
            state     <= ST_LOAD;
            cfg_ready <= 1'b1;
            beat_cnt  <= '0;
            shadow    <= '0;
        end else if (beat_acc) begin
            shadow <= shadow_merged;
            if (last_beat) begin
                active     <= shadow_merged;
                tbl_gen    <= tbl_gen + 4'd1;
                tbl_loaded <= 1'b1;
                state      <= ST_ARMED;
                cfg_ready  <= 1'b0;
                beat_cnt   <= '0;
            end else begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

    // Eval path. It reads the pre-edge active table, so an eval sampled on
    // a commit edge still sees the old function.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_r     <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            out_r     <= in_valid && active[in_data];
            out_err   <= in_valid && !tbl_loaded;
        end
    end

endmodule
